// File: rtl/mult_if.sv
//------------------------------------------------------------------------------
// mult_if
// Start/result bus between the multicycle control unit and the sequential
// Booth multiplier.
//   a, b          : 32-bit two's-complement operands (controller -> mult)
//   mult_control  : start request                     (controller -> mult)
//   hi, lo        : product bits [63:32] / [31:0]     (mult -> controller)
//   operando      : busy                              (mult -> controller)
//   pronto        : one-cycle done pulse              (mult -> controller)
// Modports: master = controller side, slave = multiplier side.
//------------------------------------------------------------------------------
interface mult_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        mult_control;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        operando;
    logic        pronto;

    modport master (
        output a,
        output b,
        output mult_control,
        input  hi,
        input  lo,
        input  operando,
        input  pronto
    );

    modport slave (
        input  a,
        input  b,
        input  mult_control,
        output hi,
        output lo,
        output operando,
        output pronto
    );
endinterface

// File: rtl/mult.sv
//------------------------------------------------------------------------------
// mult
// Sequential signed 32x32 -> 64-bit multiplier, radix-2 Booth recoding,
// one add/subtract-and-shift step per clock. Shares the HI/LO result
// convention of the divider: pulse start, wait while busy, read hi/lo.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state and outputs
//   bus    : mult_if.slave (a, b, mult_control in; hi, lo, operando, pronto out)
//
// Timing: the start edge E0 loads the operands, E1..E32 perform the Booth
// steps, E33 writes hi/lo, drops operando and raises pronto, E34 clears
// pronto and may accept the next start. All outputs are registered.
//------------------------------------------------------------------------------
module mult (
    input  logic        clk,
    input  logic        reset,
    mult_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Booth datapath registers
    logic [32:0] r_acc;     // A: 33 bits so M = -2^31 never overflows
    logic [31:0] r_m;       // latched multiplicand
    logic [31:0] r_q;       // multiplier, shifts out as product low half
    logic        r_q1;      // Booth history bit
    logic [5:0]  r_cnt;     // remaining Booth steps

    // registered outputs
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_operando;
    logic        r_pronto;

    // FSM decoded controls
    logic        w_load;
    logic        w_step;
    logic        w_write;

    logic [32:0] w_m_ext;
    logic [32:0] w_sum;
    logic [5:0]  w_cnt_next;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.mult_control) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // leave once the step that takes cnt to zero has been done
                if (w_cnt_next == 6'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: output decode (start is ignored outside IDLE, never queued)
    //--------------------------------------------------------------------------
    always_comb begin
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            S_IDLE:  w_load  = bus.mult_control;
            S_RUN:   w_step  = 1'b1;
            S_DONE:  w_write = 1'b1;
            default: begin
                w_load  = 1'b0;
                w_step  = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Booth step: add/subtract selected by {Q[0], q_1}
    //--------------------------------------------------------------------------
    always_comb begin
        w_m_ext = {r_m[31], r_m};
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
    end

    assign w_cnt_next = r_cnt - 6'd1;

    //--------------------------------------------------------------------------
    // Datapath registers. The arithmetic shift of {A,Q,q_1} takes the
    // post-add accumulator: its sign bit is replicated into A[32], its LSB
    // drops into Q[31], and Q[0] becomes the new history bit.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_m   <= bus.a;
            r_q   <= bus.b;
            r_q1  <= 1'b0;
            r_cnt <= 6'd32;
        end else if (w_step) begin
            r_acc <= {w_sum[32], w_sum[32:1]};
            r_q   <= {w_sum[0], r_q[31:1]};
            r_q1  <= r_q[0];
            r_cnt <= w_cnt_next;
        end
    end

    //--------------------------------------------------------------------------
    // Result and handshake registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_operando <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            if (w_write) begin
                r_hi <= r_acc[31:0];
                r_lo <= r_q;
            end
            if (w_load) begin
                r_operando <= 1'b1;
            end else if (w_write) begin
                r_operando <= 1'b0;
            end
            r_pronto <= w_write;
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.operando = r_operando;
    assign bus.pronto   = r_pronto;

endmodule

// File: tb/tb_mult.sv
//------------------------------------------------------------------------------
// tb_mult
// Directed self-checking bench for the sequential Booth multiplier.
// Expected products are hand-computed constants; a short back-to-back run
// compares against a 64-bit signed reference product.
//------------------------------------------------------------------------------
module tb_mult;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mult_if mif ();

    mult dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation with a start pulse; checks busy length, done pulse
    // and the product.
    task automatic do_mult(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        @(negedge clk);
        mif.a = ta;
        mif.b = tb;
        mif.mult_control = 1'b1;
        @(posedge clk);
        #1;
        mif.mult_control = 1'b0;
        check({tag, "_busy_e0"}, {63'd0, mif.operando}, 64'd1);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (mif.operando && k < 40);
        check({tag, "_busy_cycles"}, 64'(k), 64'd33);
        check({tag, "_pronto"}, {63'd0, mif.pronto}, 64'd1);
        check({tag, "_prod"}, {mif.hi, mif.lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        check({tag, "_pronto_clr"}, {63'd0, mif.pronto}, 64'd0);
    endtask

    initial begin
        int k;
        logic [31:0] ra, rb;
        logic signed [63:0] sa, sb, sp;

        n_checks = 0;
        n_errors = 0;
        mif.a = '0;
        mif.b = '0;
        mif.mult_control = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, mif.hi}, 64'd0);
        check("rst_lo", {32'd0, mif.lo}, 64'd0);
        check("rst_busy", {63'd0, mif.operando}, 64'd0);
        check("rst_pronto", {63'd0, mif.pronto}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed products
        do_mult("3x5",      32'd3,          32'd5,          32'h00000000, 32'h0000000F);
        do_mult("m3x5",     32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1);
        do_mult("m1xm1",    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001);
        do_mult("min_sq",   32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000);
        do_mult("minx1",    32'h80000000,   32'd1,          32'hFFFFFFFF, 32'h80000000);
        do_mult("max_sq",   32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001);
        do_mult("maxxmin",  32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000);
        do_mult("zero",     32'd0,          32'h12345678,   32'h00000000, 32'h00000000);

        // operand changes and a stray start during RUN must be ignored
        @(negedge clk);
        mif.a = 32'd7;
        mif.b = 32'd6;
        mif.mult_control = 1'b1;
        @(posedge clk);                       // E0
        #1;
        mif.mult_control = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            mif.a = $urandom;
            mif.b = $urandom;
            mif.mult_control = (k == 9);      // sampled at E10
            @(posedge clk);
            #1;
            k++;
        end while (mif.operando && k < 40);
        mif.mult_control = 1'b0;
        check("ign_busy_cycles", 64'(k), 64'd33);
        check("ign_prod", {mif.hi, mif.lo}, {32'd0, 32'd42});
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_restart", {63'd0, mif.operando}, 64'd0);

        // asynchronous reset in the middle of an operation
        do_mult("2x3", 32'd2, 32'd3, 32'd0, 32'd6);
        @(negedge clk);
        mif.a = 32'd100;
        mif.b = 32'd100;
        mif.mult_control = 1'b1;
        @(posedge clk);                       // E0
        #1;
        mif.mult_control = 1'b0;
        repeat (15) @(posedge clk);           // E15
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, mif.operando}, 64'd0);
        check("abort_prod", {mif.hi, mif.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_mult("m1x10", 32'hFFFFFFFF, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFF6);

        // back-to-back with start held high: restart at every E34
        @(negedge clk);
        ra = $urandom;
        rb = $urandom;
        mif.a = ra;
        mif.b = rb;
        mif.mult_control = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 150; i++) begin
            sa = {{32{ra[31]}}, ra};
            sb = {{32{rb[31]}}, rb};
            sp = sa * sb;
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while (!mif.pronto && k < 40);
            check("b2b_done", 64'(k), 64'd33);
            check("b2b_prod", {mif.hi, mif.lo}, sp);
            ra = $urandom;
            rb = $urandom;
            mif.a = ra;
            mif.b = rb;
            if (i == 149) mif.mult_control = 1'b0;
            @(posedge clk);                   // E34
            #1;
            check("b2b_restart", {63'd0, mif.operando}, (i == 149) ? 64'd0 : 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
